decode_prefix_seq: RTL and testbench
====================================

Name: decode_prefix_seq

Overview:
- Byte-serial x86 prefix collector for the decode stage. Consumes one instruction byte per accepted handshake and accumulates group 1–4 prefixes plus the 0F escape.
- On the first opcode byte, emits a registered per-instruction bundle through a one-entry output buffer with valid/ready.
- Generalises the prefix tracker with:
  - a parametrised prefix-count limit and fault,
  - duplicate-prefix reporting,
  - an escape state in which bytes are never treated as prefixes,
  - flush and backpressure.

Parameters:
MAX_PREFIX, 14, max prefix bytes (0F counts as one) before fault; legal 1..14
CNT_W, 4, width of prefix counter; must satisfy 2**CNT_W > MAX_PREFIX
DEFAULT_SEG, 3, segment code emitted when no group-2 prefix seen (3 = DS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cs_d_b  in  1  CS descriptor D/B bit, default operand/address size
flush  in  1  abort current instruction, drop output buffer
in_valid  in  1  in_byte valid
in_byte  in  8  next instruction byte
in_ready  out  1  byte accepted when in_valid & in_ready
out_valid  out  1  bundle valid
out_ready  in  1  downstream accepts bundle
out_opcode  out  8  first non-prefix byte (offending byte on fault)
out_2byte  out  1  0F escape seen
out_operand_32bit  out  1  cs_d_b ^ 66 seen
out_address_32bit  out  1  cs_d_b ^ 67 seen
out_rep  out  2  0 none, 1 F2, 2 F3
out_lock  out  1  F0 seen
out_seg  out  3  0..5 ES,CS,SS,DS,FS,GS; DEFAULT_SEG if none
out_prefix_count  out  CNT_W  prefix bytes consumed
out_redundant  out  1  some prefix group written more than once
out_fault  out  1  prefix limit exceeded

Behaviour:
- Reset:
  - state S_PREFIX; all accumulators clear (seg accumulator 7 = none).
  - out_valid=0. All out_* registers 0, except out_seg=DEFAULT_SEG.
- in_ready = ~out_valid | out_ready. Accepting a byte and draining the buffer in the same cycle is legal.
- Prefix set: F2 F3 F0 26 2E 36 3E 64 65 66 67 0F.
- Groups for redundancy:
  - rep {F2,F3}
  - lock {F0}
  - seg {26,2E,36,3E,64,65}
  - opsz {66}
  - adsz {67}
  - A write to a group already set sets a sticky redundant flag.
- Group values: rep and seg are last-wins. Lock, opsz and adsz are sticky.
- State S_PREFIX, on each accepted byte:
  - Non-prefix byte: load bundle (out_opcode=byte) and set out_valid. Clear accumulators and count the same edge. Stay in S_PREFIX.
  - Prefix byte with count == MAX_PREFIX: load bundle with out_fault=1 and out_opcode=byte. Clear accumulators and return to S_PREFIX.
  - 0F: set escape and count+1, go to S_ESC.
  - Any other prefix: update its group, count+1.
- State S_ESC:
  - The next accepted byte is always the opcode, even if it is in the prefix set.
  - Load bundle with out_2byte=1, clear accumulators, return to S_PREFIX.
- Bundle fields:
  - Size bits are computed from cs_d_b sampled at the load edge.
  - out_seg = accumulator, or DEFAULT_SEG if the accumulator is 7.
- out_valid clears on out_valid & out_ready unless a new bundle loads the same edge.
- flush has priority over everything:
  - clear out_valid and accumulators, go to S_PREFIX, ignore the byte presented that cycle.
  - in_ready is still computed normally.
- Stall: when in_ready=0, no accumulator or state changes. Held bytes are not consumed.
- Count never wraps; the fault path guarantees count ≤ MAX_PREFIX.

Decomposition:
- Shared package (decode package):
  - prefix byte constants
  - segment codes ES..GS and NONE=7
  - rep encodings
  - state encoding S_PREFIX/S_ESC
- One natural sub-module, prefix_classify: combinational byte → {is_prefix, group id, group value}. Reusable by parallel-decode variants.
- Sequencing, accumulators and the output buffer stay in the top module.

Test Plan:
- cs_d_b=0; bytes 66,2E,8B with out_ready=1 → one bundle: opcode 8B, operand_32bit=1, address_32bit=0, seg=1, count=2, redundant=0, fault=0.
- Bytes 26,64,F3,F2,A4 → seg=4, rep=1, count=4, redundant=1.
- cs_d_b=1; bytes 0F,66 → opcode 66, 2byte=1, operand_32bit=1, count=1 (66 not treated as prefix after escape).
- MAX_PREFIX=14; fifteen bytes of 66 → bundle on the 15th byte with fault=1, opcode 66, count=14. A following byte 90 gives a clean bundle with count=0 and fault=0.
- Bundle pending with out_ready=0 → in_ready=0 and the next byte is held. Raise out_ready → drain and accept in the same cycle, with the new bundle valid next cycle.
- Bytes 67,F0 then flush; then 90 → bundle with address_32bit=cs_d_b, lock=0, count=0. Assert rst_n low mid-prefix → out_valid=0 and out_seg=3 immediately.

Source files
------------

// File: rtl/decode_prefix_seq_pkg.sv
// rtl/decode_prefix_seq_pkg.sv - shared constants and encodings for the x86 prefix collector
package decode_prefix_seq_pkg;

    localparam logic [7:0] PFX_REPNE = 8'hF2;
    localparam logic [7:0] PFX_REP   = 8'hF3;
    localparam logic [7:0] PFX_LOCK  = 8'hF0;
    localparam logic [7:0] PFX_ES    = 8'h26;
    localparam logic [7:0] PFX_CS    = 8'h2E;
    localparam logic [7:0] PFX_SS    = 8'h36;
    localparam logic [7:0] PFX_DS    = 8'h3E;
    localparam logic [7:0] PFX_FS    = 8'h64;
    localparam logic [7:0] PFX_GS    = 8'h65;
    localparam logic [7:0] PFX_OPSZ  = 8'h66;
    localparam logic [7:0] PFX_ADSZ  = 8'h67;
    localparam logic [7:0] PFX_ESC   = 8'h0F;

    localparam logic [2:0] SEG_ES   = 3'd0;
    localparam logic [2:0] SEG_CS   = 3'd1;
    localparam logic [2:0] SEG_SS   = 3'd2;
    localparam logic [2:0] SEG_DS   = 3'd3;
    localparam logic [2:0] SEG_FS   = 3'd4;
    localparam logic [2:0] SEG_GS   = 3'd5;
    localparam logic [2:0] SEG_NONE = 3'd7;

    localparam logic [1:0] REP_NONE = 2'd0;
    localparam logic [1:0] REP_F2   = 2'd1;
    localparam logic [1:0] REP_F3   = 2'd2;

    typedef enum logic {
        S_PREFIX,
        S_ESC
    } state_t;

    typedef enum logic [2:0] {
        GRP_NONE,
        GRP_REP,
        GRP_LOCK,
        GRP_SEG,
        GRP_OPSZ,
        GRP_ADSZ,
        GRP_ESC
    } group_t;

endpackage

// File: rtl/decode_prefix_seq_prefix_classify.sv
// rtl/decode_prefix_seq_prefix_classify.sv - combinational byte to prefix group/value classifier
module prefix_classify
    import decode_prefix_seq_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_is_prefix,
    output group_t     o_group,
    output logic [2:0] o_value
);

    always_comb begin
        o_is_prefix = 1'b1;
        o_group     = GRP_NONE;
        o_value     = 3'd0;
        case (i_byte)
            PFX_REPNE: begin o_group = GRP_REP;  o_value = {1'b0, REP_F2}; end
            PFX_REP:   begin o_group = GRP_REP;  o_value = {1'b0, REP_F3}; end
            PFX_LOCK:  o_group = GRP_LOCK;
            PFX_ES:    begin o_group = GRP_SEG;  o_value = SEG_ES; end
            PFX_CS:    begin o_group = GRP_SEG;  o_value = SEG_CS; end
            PFX_SS:    begin o_group = GRP_SEG;  o_value = SEG_SS; end
            PFX_DS:    begin o_group = GRP_SEG;  o_value = SEG_DS; end
            PFX_FS:    begin o_group = GRP_SEG;  o_value = SEG_FS; end
            PFX_GS:    begin o_group = GRP_SEG;  o_value = SEG_GS; end
            PFX_OPSZ:  o_group = GRP_OPSZ;
            PFX_ADSZ:  o_group = GRP_ADSZ;
            PFX_ESC:   o_group = GRP_ESC;
            default:   o_is_prefix = 1'b0;
        endcase
    end

endmodule

// File: rtl/decode_prefix_seq.sv
// rtl/decode_prefix_seq.sv - byte-serial prefix collector with one-entry bundle buffer
module decode_prefix_seq #(
    parameter int         MAX_PREFIX  = 14,
    parameter int         CNT_W       = 4,
    parameter logic [2:0] DEFAULT_SEG = 3'd3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs_d_b,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_opcode,
    output logic             out_2byte,
    output logic             out_operand_32bit,
    output logic             out_address_32bit,
    output logic [1:0]       out_rep,
    output logic             out_lock,
    output logic [2:0]       out_seg,
    output logic [CNT_W-1:0] out_prefix_count,
    output logic             out_redundant,
    output logic             out_fault
);
    import decode_prefix_seq_pkg::*;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_rep;
    logic             r_lock;
    logic [2:0]       r_seg;
    logic             r_opsz;
    logic             r_adsz;
    logic             r_redundant;

    logic             w_is_prefix;
    group_t           w_group;
    logic [2:0]       w_value;
    logic             w_accept;
    logic             w_in_esc;
    logic             w_at_limit;
    logic             w_load;
    logic             w_fault;
    logic             w_dup;

    prefix_classify u_classify (
        .i_byte      (in_byte),
        .o_is_prefix (w_is_prefix),
        .o_group     (w_group),
        .o_value     (w_value)
    );

    assign in_ready   = ~out_valid | out_ready;
    assign w_accept   = in_valid & in_ready;
    assign w_in_esc   = (r_state == S_ESC);
    assign w_at_limit = (r_cnt == CNT_W'(MAX_PREFIX));
    // After 0F every byte is the opcode, so neither prefix nor limit logic applies there.
    assign w_fault    = ~w_in_esc & w_is_prefix & w_at_limit;
    assign w_load     = w_accept & (w_in_esc | ~w_is_prefix | w_at_limit);

    always_comb begin
        w_dup = 1'b0;
        case (w_group)
            GRP_REP:  w_dup = (r_rep != REP_NONE);
            GRP_LOCK: w_dup = r_lock;
            GRP_SEG:  w_dup = (r_seg != SEG_NONE);
            GRP_OPSZ: w_dup = r_opsz;
            GRP_ADSZ: w_dup = r_adsz;
            default:  w_dup = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= S_PREFIX;
            r_cnt             <= '0;
            r_rep             <= REP_NONE;
            r_lock            <= 1'b0;
            r_seg             <= SEG_NONE;
            r_opsz            <= 1'b0;
            r_adsz            <= 1'b0;
            r_redundant       <= 1'b0;
            out_valid         <= 1'b0;
            out_opcode        <= '0;
            out_2byte         <= 1'b0;
            out_operand_32bit <= 1'b0;
            out_address_32bit <= 1'b0;
            out_rep           <= REP_NONE;
            out_lock          <= 1'b0;
            out_seg           <= DEFAULT_SEG;
            out_prefix_count  <= '0;
            out_redundant     <= 1'b0;
            out_fault         <= 1'b0;
        end else if (flush) begin
            r_state     <= S_PREFIX;
            r_cnt       <= '0;
            r_rep       <= REP_NONE;
            r_lock      <= 1'b0;
            r_seg       <= SEG_NONE;
            r_opsz      <= 1'b0;
            r_adsz      <= 1'b0;
            r_redundant <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            if (w_load) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (w_load) begin
                out_opcode        <= in_byte;
                out_2byte         <= w_in_esc;
                out_operand_32bit <= cs_d_b ^ r_opsz;
                out_address_32bit <= cs_d_b ^ r_adsz;
                out_rep           <= r_rep;
                out_lock          <= r_lock;
                out_seg           <= (r_seg == SEG_NONE) ? DEFAULT_SEG : r_seg;
                out_prefix_count  <= r_cnt;
                out_redundant     <= r_redundant;
                out_fault         <= w_fault;
                r_state           <= S_PREFIX;
                r_cnt             <= '0;
                r_rep             <= REP_NONE;
                r_lock            <= 1'b0;
                r_seg             <= SEG_NONE;
                r_opsz            <= 1'b0;
                r_adsz            <= 1'b0;
                r_redundant       <= 1'b0;
            end else if (w_accept) begin
                r_cnt       <= r_cnt + 1'b1;
                r_redundant <= r_redundant | w_dup;
                case (w_group)
                    GRP_REP:  r_rep   <= w_value[1:0];
                    GRP_LOCK: r_lock  <= 1'b1;
                    GRP_SEG:  r_seg   <= w_value;
                    GRP_OPSZ: r_opsz  <= 1'b1;
                    GRP_ADSZ: r_adsz  <= 1'b1;
                    GRP_ESC:  r_state <= S_ESC;
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decode_prefix_seq.sv
// tb/tb_decode_prefix_seq.sv - randomized scoreboard bench for decode_prefix_seq
module tb_decode_prefix_seq;

    localparam int MAX = 14;

    typedef struct {
        logic [7:0] op;
        logic       two;
        logic       op32;
        logic       ad32;
        logic [1:0] rep;
        logic       lock;
        logic [2:0] seg;
        logic [3:0] cnt;
        logic       red;
        logic       fault;
    } bundle_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_d_b = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_opcode;
    logic       out_2byte;
    logic       out_operand_32bit;
    logic       out_address_32bit;
    logic [1:0] out_rep;
    logic       out_lock;
    logic [2:0] out_seg;
    logic [3:0] out_prefix_count;
    logic       out_redundant;
    logic       out_fault;

    int         n_cmp = 0;
    int         n_bad = 0;
    bundle_t    exp_q[$];
    logic [7:0] pfx_q[$];
    logic [7:0] pfx_tab [12] = '{8'hF2, 8'hF3, 8'hF0, 8'h26, 8'h2E, 8'h36,
                                 8'h3E, 8'h64, 8'h65, 8'h66, 8'h67, 8'h0F};

    decode_prefix_seq #(.MAX_PREFIX(MAX), .CNT_W(4), .DEFAULT_SEG(3'd3)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cs_d_b            (cs_d_b),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_byte           (in_byte),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_opcode        (out_opcode),
        .out_2byte         (out_2byte),
        .out_operand_32bit (out_operand_32bit),
        .out_address_32bit (out_address_32bit),
        .out_rep           (out_rep),
        .out_lock          (out_lock),
        .out_seg           (out_seg),
        .out_prefix_count  (out_prefix_count),
        .out_redundant     (out_redundant),
        .out_fault         (out_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_pfx(input logic [7:0] b);
        return b inside {8'hF2, 8'hF3, 8'hF0, 8'h26, 8'h2E, 8'h36, 8'h3E,
                         8'h64, 8'h65, 8'h66, 8'h67, 8'h0F};
    endfunction

    // Reference: the instruction is the list of prefixes seen so far plus the terminating byte.
    task automatic model_byte(input logic [7:0] b, input logic csdb);
        bundle_t e;
        bit esc;
        bit pf;
        int n_rep, n_lock, n_seg, n_op, n_ad;
        esc = (pfx_q.size() > 0) && (pfx_q[pfx_q.size()-1] == 8'h0F);
        pf  = is_pfx(b);
        if (!esc && pf && pfx_q.size() < MAX) begin
            pfx_q.push_back(b);
            return;
        end
        n_rep = 0; n_lock = 0; n_seg = 0; n_op = 0; n_ad = 0;
        e.rep = 2'd0;
        e.seg = 3'd3;
        foreach (pfx_q[i]) begin
            case (pfx_q[i])
                8'hF2: begin e.rep = 2'd1; n_rep++; end
                8'hF3: begin e.rep = 2'd2; n_rep++; end
                8'hF0: n_lock++;
                8'h26: begin e.seg = 3'd0; n_seg++; end
                8'h2E: begin e.seg = 3'd1; n_seg++; end
                8'h36: begin e.seg = 3'd2; n_seg++; end
                8'h3E: begin e.seg = 3'd3; n_seg++; end
                8'h64: begin e.seg = 3'd4; n_seg++; end
                8'h65: begin e.seg = 3'd5; n_seg++; end
                8'h66: n_op++;
                8'h67: n_ad++;
                default: ;
            endcase
        end
        e.op    = b;
        e.two   = esc;
        e.op32  = csdb ^ (n_op > 0);
        e.ad32  = csdb ^ (n_ad > 0);
        e.lock  = (n_lock > 0);
        e.cnt   = 4'(pfx_q.size());
        e.red   = (n_rep > 1) || (n_lock > 1) || (n_seg > 1) || (n_op > 1) || (n_ad > 1);
        e.fault = !esc && pf;
        exp_q.push_back(e);
        pfx_q.delete();
    endtask

    always @(negedge clk) begin : monitor
        bundle_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_bundle: got opcode %0h expected no bundle", out_opcode);
            end else begin
                e = exp_q.pop_front();
                check("opcode", out_opcode, e.op);
                check("2byte", out_2byte, e.two);
                check("operand_32bit", out_operand_32bit, e.op32);
                check("address_32bit", out_address_32bit, e.ad32);
                check("rep", out_rep, e.rep);
                check("lock", out_lock, e.lock);
                check("seg", out_seg, e.seg);
                check("prefix_count", out_prefix_count, e.cnt);
                check("redundant", out_redundant, e.red);
                check("fault", out_fault, e.fault);
            end
        end
    end

    // Entered and left at one time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int ready_pct);
        int guard;
        bit done;
        guard = 0;
        done  = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!done && guard < 200) begin
            out_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            if (in_ready) begin
                model_byte(b, cs_d_b);
                done = 1;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_accept_timeout: byte %0h not accepted in 200 cycles", b);
        end
        in_valid = 1'b0;
    endtask

    task automatic flush_cycle(input logic [7:0] b);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_byte   = b;
        out_ready = 1'b0;
        @(negedge clk);
        pfx_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", out_valid, 1'b0);
        check("async_reset_out_seg", out_seg, 3'd3);
        pfx_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int r;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_seg", out_seg, 3'd3);
        check("reset_out_opcode", out_opcode, 8'h00);
        check("reset_prefix_count", out_prefix_count, 4'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1'b1);

        cs_d_b = 1'b0;
        send_byte(8'h66, 100); send_byte(8'h2E, 100); send_byte(8'h8B, 100);
        send_byte(8'h26, 100); send_byte(8'h64, 100); send_byte(8'hF3, 100);
        send_byte(8'hF2, 100); send_byte(8'hA4, 100);
        cs_d_b = 1'b1;
        send_byte(8'h0F, 100); send_byte(8'h66, 100);
        for (int k = 0; k < 15; k++) send_byte(8'h66, 100);
        send_byte(8'h90, 100);

        // Backpressure: a held bundle must stall the next byte until drain.
        send_byte(8'h90, 100);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_byte   = 8'h91;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_in_ready", in_ready, 1'b1);
        if (in_ready) model_byte(8'h91, cs_d_b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("drain_accept_out_valid", out_valid, 1'b1);
        check("drain_accept_opcode", out_opcode, 8'h91);

        cs_d_b = 1'b0;
        send_byte(8'h67, 100); send_byte(8'hF0, 100);
        flush_cycle(8'h90);
        send_byte(8'h90, 100);

        send_byte(8'h2E, 100); send_byte(8'h90, 100);
        out_ready = 1'b0;
        check("held_bundle_valid", out_valid, 1'b1);
        pulse_reset();
        cs_d_b = 1'b1;
        send_byte(8'h67, 100); send_byte(8'hF0, 100);
        pulse_reset();
        send_byte(8'h90, 100);

        for (int i = 0; i < 500; i++) begin
            cs_d_b = 1'($urandom_range(1));
            r = $urandom_range(99);
            if (r < 3) begin
                flush_cycle(8'($urandom));
            end else if (r < 7) begin
                for (int k = 0; k < 15; k++) send_byte(pfx_tab[$urandom_range(10)], 70);
            end else if (r < 55) begin
                send_byte(pfx_tab[$urandom_range(11)], 70);
            end else begin
                send_byte(8'($urandom), 70);
            end
        end
        send_byte(8'h90, 70);

        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        check("final_out_valid", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
